// File: rtl/instr_enc_pkg.sv
// MIPS encoder shared types: mnemonics, opcode/func codes, field positions.
// Encoding helpers used by the instr_encoder loader.
package instr_enc_pkg;

  localparam int MNEM_W = 5;

  typedef enum logic [MNEM_W-1:0] {
    M_SLL = 5'd0, M_SRL, M_SRA, M_JR, M_SYSCALL,
    M_ADD, M_ADDU, M_SUB, M_AND, M_OR,
    M_XOR, M_NOR, M_SLT, M_SLTU,
    M_J, M_JAL,
    M_BEQ, M_BNE, M_BGEZ,
    M_ADDI, M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI,
    M_LW, M_LHU, M_SW
  } mnem_e;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DONE
  } state_e;

  typedef struct packed {
    logic        rej;
    logic [31:0] word;
  } enc_t;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

  localparam logic [5:0] OP_BGEZ  = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_LHU   = 6'd37;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_SRA  = 6'd3;
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_SYS  = 6'd12;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SLTU = 6'd43;

  localparam logic [4:0] BGEZ_RT = 5'd1;

  function automatic logic is_shift(logic [MNEM_W-1:0] m);
    return m <= M_SRA;
  endfunction

  function automatic logic is_alu(logic [MNEM_W-1:0] m);
    return (m >= M_ADD) && (m <= M_SLTU);
  endfunction

  function automatic logic is_jmp(logic [MNEM_W-1:0] m);
    return (m == M_J) || (m == M_JAL);
  endfunction

  function automatic logic is_imm(logic [MNEM_W-1:0] m);
    return (m >= M_BEQ) && (m <= M_SW) && (m != M_BGEZ);
  endfunction

  function automatic logic [5:0] func_of(logic [MNEM_W-1:0] m);
    logic [5:0] f;
    f = 6'd0;
    case (m)
      M_SLL:     f = FN_SLL;
      M_SRL:     f = FN_SRL;
      M_SRA:     f = FN_SRA;
      M_JR:      f = FN_JR;
      M_SYSCALL: f = FN_SYS;
      M_ADD:     f = FN_ADD;
      M_ADDU:    f = FN_ADDU;
      M_SUB:     f = FN_SUB;
      M_AND:     f = FN_AND;
      M_OR:      f = FN_OR;
      M_XOR:     f = FN_XOR;
      M_NOR:     f = FN_NOR;
      M_SLT:     f = FN_SLT;
      M_SLTU:    f = FN_SLTU;
      default:   f = 6'd0;
    endcase
    return f;
  endfunction

  function automatic logic [5:0] op_of(logic [MNEM_W-1:0] m);
    logic [5:0] o;
    o = 6'd0;
    case (m)
      M_BGEZ:  o = OP_BGEZ;
      M_J:     o = OP_J;
      M_JAL:   o = OP_JAL;
      M_BEQ:   o = OP_BEQ;
      M_BNE:   o = OP_BNE;
      M_ADDI:  o = OP_ADDI;
      M_ADDIU: o = OP_ADDIU;
      M_SLTI:  o = OP_SLTI;
      M_ANDI:  o = OP_ANDI;
      M_ORI:   o = OP_ORI;
      M_XORI:  o = OP_XORI;
      M_LW:    o = OP_LW;
      M_LHU:   o = OP_LHU;
      M_SW:    o = OP_SW;
      default: o = 6'd0;
    endcase
    return o;
  endfunction

  // True when a field the instruction format ignores carries a nonzero value.
  function automatic logic has_unused(
    logic [MNEM_W-1:0] m,
    logic [4:0]        rs,
    logic [4:0]        rt,
    logic [4:0]        rd,
    logic [4:0]        sh,
    logic [15:0]       imm,
    logic [25:0]       tgt
  );
    logic u;
    u = 1'b0;
    unique case (1'b1)
      is_shift(m):    u = |{rs, imm, tgt};
      is_alu(m):      u = |{sh, imm, tgt};
      m == M_JR:      u = |{rt, rd, sh, imm, tgt};
      m == M_SYSCALL: u = |{rs, rt, rd, sh, imm, tgt};
      is_imm(m):      u = |{rd, sh, tgt};
      m == M_BGEZ:    u = |{rt, rd, sh, tgt};
      is_jmp(m):      u = |{rs, rt, rd, sh, imm};
      default:        u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Small synchronous FIFO for encoded words.
// Flush empties it in one cycle; reports full/empty/occupancy.
module instr_enc_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign occ     = wptr - rptr;
  assign full    = occ == (AW+1)'(DEPTH);
  assign empty   = wptr == rptr;
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; flush discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder / program loader into instruction memory.
// Optional INSTR_ENC_STRICT_EN: reject requests with nonzero unused fields.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [MNEM_W-1:0] req_mnem,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = ADDR_W + 2;
  localparam logic [SUM_W-1:0] LIMIT = SUM_W'(1) << ADDR_W;
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  function automatic enc_t encode(
    logic [MNEM_W-1:0] m,
    logic [4:0]        rs,
    logic [4:0]        rt,
    logic [4:0]        rd,
    logic [4:0]        sh,
    logic [15:0]       imm,
    logic [25:0]       tgt
  );
    enc_t e;
    e.word = '0;
    e.rej  = 1'b0;
    unique case (1'b1)
      is_shift(m): begin
        e.word[RT_LSB +: 5] = rt;
        e.word[RD_LSB +: 5] = rd;
        e.word[SH_LSB +: 5] = sh;
        e.word[5:0]         = func_of(m);
      end
      is_alu(m): begin
        e.word[RS_LSB +: 5] = rs;
        e.word[RT_LSB +: 5] = rt;
        e.word[RD_LSB +: 5] = rd;
        e.word[5:0]         = func_of(m);
      end
      m == M_JR: begin
        e.word[RS_LSB +: 5] = rs;
        e.word[5:0]         = func_of(m);
      end
      m == M_SYSCALL: begin
        e.word[5:0] = func_of(m);
      end
      is_imm(m): begin
        e.word[OP_LSB +: 6] = op_of(m);
        e.word[RS_LSB +: 5] = rs;
        e.word[RT_LSB +: 5] = rt;
        e.word[15:0]        = imm;
      end
      m == M_BGEZ: begin
        e.word[OP_LSB +: 6] = op_of(m);
        e.word[RS_LSB +: 5] = rs;
        e.word[RT_LSB +: 5] = BGEZ_RT;
        e.word[15:0]        = imm;
      end
      is_jmp(m): begin
        e.word[OP_LSB +: 6] = op_of(m);
        e.word[25:0]        = tgt;
      end
      default: e.rej = 1'b1;
    endcase
`ifdef INSTR_ENC_STRICT_EN
    if (has_unused(m, rs, rt, rd, sh, imm, tgt)) e.rej = 1'b1;
`endif
    return e;
  endfunction

  state_e           state;
  state_e           state_nx;
  enc_t             enc;
  logic             hs;
  logic             push;
  logic             wr;
  logic             full;
  logic             empty;
  logic [OCC_W-1:0] occ;
  logic [31:0]      head;
  logic [SUM_W-1:0] pending;

  assign enc = encode(req_mnem, req_rs, req_rt, req_rd,
                      req_shamt, req_imm, req_target);
  assign hs      = req_valid && req_ready;
  assign push    = hs && !enc.rej;
  assign wr      = mem_we && mem_ready;
  assign pending = SUM_W'(count) + SUM_W'(occ);

  instr_enc_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push  (push),
    .wdata (enc.word),
    .pop   (wr),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .occ   (occ)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state: start always restarts; last address slot ends the run.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = S_RUN;
    end else if (state == S_RUN && wr && count == LAST) begin
      state_nx = S_DONE;
    end
  end

  // Handshake and memory-side outputs.
  always_comb begin
    req_ready = (state == S_RUN) && !full && !start &&
                (pending != LIMIT);
    busy      = (state == S_RUN) || !empty;
    mem_we    = !empty;
    mem_wdata = empty ? 32'd0 : head;
  end

  // Write address, written-word count and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else if (start) begin
      mem_addr <= base_addr;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      if (wr) begin
        mem_addr <= mem_addr + 1'b1;
        count    <= count + 1'b1;
      end
      if (hs && enc.rej) err <= 1'b1;
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Assembles MIPS instruction words from a mnemonic ID plus operand fields. It is the encode-side counterpart of the op/func control decoder, and accepts exactly the instruction subset the decoder understands. Encoded words are buffered in a small FIFO and streamed into instruction memory at consecutive word addresses, starting from a loaded base. The block serves as the test-program loader and debug injector ahead of the single-cycle CPU.

Parameters:
ADDR_W, 10, instruction-memory word-address width
FIFO_DEPTH, 2, encoded-word FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  pulse: load base_addr, clear count/err, flush FIFO, enter RUN
base_addr  in  ADDR_W  first word address written after start
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&&req_ready
req_mnem  in  5  mnemonic ID (package enum)
req_rs, req_rt, req_rd, req_shamt  in  5 each  register/shift fields
req_imm  in  16  immediate / branch offset
req_target  in  26  jump target field
mem_we  out  1  write strobe; high whenever FIFO non-empty
mem_addr  out  ADDR_W  word address of current write
mem_wdata  out  32  FIFO head word
mem_ready  in  1  memory accepts write when mem_we&&mem_ready
busy  out  1  state==RUN or FIFO non-empty
err  out  1  sticky: an illegal/rejected request was seen
count  out  ADDR_W+1  words written since start

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO empty; mem_we=0, mem_addr=0, mem_wdata=0, req_ready=0, busy=0, err=0, count=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN on start.
  - RUN->DONE when the write that makes count==2^ADDR_W completes.
  - DONE->RUN on start.
  - start in any state forces RUN with the full flush.
- req_ready = (state==RUN) && !fifo_full && !start && !(count+fifo_occupancy == 2^ADDR_W).
- Push and pop in the same cycle when full: allowed, but req_ready does not rise until the next cycle.
- Encoding is combinational from the request fields and registered into the FIFO on handshake; the word appears on mem_wdata/mem_we the next cycle at the earliest (latency 1).
- R-type: op=0, fields rs[25:21], rt[20:16], rd[15:11], shamt[10:6], func[5:0].
  - func values: SLL 0, SRL 2, SRA 3, JR 8, SYSCALL 12, ADD 32, ADDU 33, SUB 34, AND 36, OR 37, XOR 38, NOR 39, SLT 42, SLTU 43.
  - Shift instructions use rs=0.
  - JR uses only rs.
  - SYSCALL encodes 0x0000000C.
- I-type: op[31:26], rs, rt, imm[15:0].
  - op values: BEQ 4, BNE 5, ADDI 8, ADDIU 9, SLTI 10, ANDI 12, ORI 13, XORI 14, LW 35, LHU 37, SW 43.
  - BGEZ: op=1, rt forced to 1.
- J-type: J op=2, JAL op=3, target[25:0].
- Fields an instruction does not use are forced to 0 in the encoded word.
- Illegal mnemonic (28-31): the handshake completes, nothing is pushed, err is set.
- Write: on mem_we&&mem_ready, pop the FIFO, mem_addr += 1 (wraps mod 2^ADDR_W), count += 1.
- mem_we stays high and mem_addr/mem_wdata stay stable while mem_ready=0.
- start during pending writes: the FIFO is discarded and no further writes occur for those words.
- rst mid-stream: returns to IDLE immediately; mem_we drops asynchronously.

Optional Feature:
Macro: INSTR_ENC_STRICT_EN.
- Defined: a request with a nonzero unused field is rejected exactly like an illegal mnemonic (accepted, not pushed, err set). Examples of unused fields: shamt on ADD, rd on any I-type, rt on BGEZ, rs on SLL.
- Not defined: unused fields are silently zeroed and the word is pushed.

Decomposition:
- Package instr_enc_pkg holds:
  - mnemonic enum (SLL=0 … SW=27; values 28-31 illegal);
  - opcode and func constants;
  - field bit-position constants;
  - MNEM_W=5.
- One sub-module, instr_enc_fifo: synchronous FIFO with full/empty/occupancy outputs, async active-high reset.
- The encoder logic is a pure function in the top module.

Test Plan:
- Encoding:
  - start with base_addr=0x010; ADD rd=3 rs=1 rt=2 -> write 0x00221820 @0x010, count=1.
  - ADDI rt=8 rs=0 imm=0xFFFF -> 0x2008FFFF.
  - SLL rd=2 rt=3 shamt=4 -> 0x00031100.
  - JR rs=31 -> 0x03E00008.
- Encoding: BGEZ rs=4 imm=3 -> 0x04810003; SW rt=9 rs=29 imm=4 -> 0xAFA90004; J target=0x0100000 -> 0x08100000; SYSCALL -> 0x0000000C; addresses increment by 1.
- Backpressure: hold mem_ready=0 for 5 cycles with 3 requests offered -> FIFO_DEPTH words buffered, req_ready=0, mem_addr/mem_wdata stable; release -> all words written in order with no loss.
- Illegal mnemonic 30 -> handshake completes, no write, err=1 until next start. Strict build: ADD with shamt=1 -> err=1, no write. Non-strict build: same request -> 0x00221820.
- Wrap and DONE: ADDR_W=4, base_addr=0xE, 16 requests -> last writes wrap 0xF->0x0; after the 16th write state=DONE, count=16, req_ready=0; start re-enters RUN.
- rst asserted while mem_we=1 -> mem_we=0 immediately, IDLE, count=0; start issued in the same cycle as req_valid -> request not accepted.
